md_hazard_ctrl: RTL and testbench
=================================

MD_HAZARD_CTRL -- requirements
Module: md_hazard_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 4: number of RUN cycles for MdOp 00 (mult) and 01 (multu).
REQ-002 Parameter DIV_CYCLES, default 32: number of RUN cycles for MdOp 10 (div) and 11 (divu).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 StartE  in  1  EX-stage instruction is a mul/div.
REQ-006 MdOpE  in  2  EX-stage mul/div opcode: 00 mult, 01 multu, 10 div, 11 divu.
REQ-007 DivZeroE  in  1  EX-stage divisor equals zero.
REQ-008 StartD  in  1  ID-stage instruction is a mul/div.
REQ-009 HiLoReadD  in  1  ID-stage instruction reads HI or LO (mfhi/mflo).
REQ-010 HiLoWriteD  in  1  ID-stage instruction writes HI or LO (mthi/mtlo).
REQ-011 MemToRegE, RtE[4:0], RsD[4:0], RtD[4:0]  in  load-use detection inputs.
REQ-012 StallF, StallD  out  1 each  hold PC and the IF/ID register.
REQ-013 FlushE  out  1  bubble into the ID/EX register.
REQ-014 MdStart  out  1  one-cycle start pulse to the iterative mul/div unit.
REQ-015 MdOp  out  2  opcode latched at start, stable until return to IDLE.
REQ-016 MdDone  out  1  one-cycle pulse: result valid; HI/LO update this cycle.
REQ-017 MdWriteEn  out  1  HI/LO write enable, valid only when MdDone=1.
REQ-018 MdBusy  out  1  high in RUN and DONE.

Function
REQ-019 States: IDLE, RUN, DONE; 6-bit down-counter Cnt.
REQ-020 IDLE with StartE=1: MdStart=1 (combinational, same cycle), latch MdOp<=MdOpE, Cnt<=MUL_CYCLES-1 or DIV_CYCLES-1, go to RUN on the next edge.
REQ-021 RUN: Cnt decrements each cycle; when Cnt==0, go to DONE on the next edge.
REQ-022 DONE lasts exactly one cycle: MdDone=1, MdWriteEn=1, then IDLE; a new op therefore takes effect no earlier than one cycle after DONE.
REQ-023 Total latency: StartE cycle to MdDone = MUL_CYCLES+1 cycles (mul) or DIV_CYCLES+1 cycles (div).
REQ-024 StartE while not IDLE is a protocol violation: ignored, no MdStart, state unaffected.
REQ-025 LoadUse = MemToRegE & (RtE!=0) & (RtE==RsD | RtE==RtD).
REQ-026 MdHazard = MdBusy & (StartD | HiLoReadD | HiLoWriteD).
REQ-027 MdHazard additionally asserts when MdStart=1 and StartD|HiLoReadD|HiLoWriteD, so no HI/LO access slips past the start cycle.
REQ-028 StallF = StallD = FlushE = LoadUse | MdHazard; all three are combinational.
REQ-029 Simultaneous DONE and a pending HiLoReadD: a stall still occurs in the DONE cycle; ID releases the next cycle and reads the updated HI/LO.
REQ-030 MdOp holds its value through DONE; it resets to 00 in IDLE only on rst.

Reset
REQ-031 rst=1 at any clock edge, including mid-RUN: state<=IDLE, Cnt<=0, MdOp<=00; the aborted operation produces no MdDone.
REQ-032 While rst=1, MdStart, MdDone, MdWriteEn, and MdBusy are forced to 0; stall outputs follow REQ-028 from inputs.
REQ-033 Power-up initial values equal the reset values.

Configuration
REQ-034 Macro MD_DIV_ZERO_FAST_EN.
- Defined: IDLE with StartE=1, MdOpE[1]=1 and DivZeroE=1 goes directly to DONE.
  - MdStart=0, MdWriteEn=0 in that DONE, so HI/LO are unchanged.
  - Latency is 1 cycle.
- Undefined: DivZeroE is ignored and the divide runs the full DIV_CYCLES; MdWriteEn=1.

Verification
REQ-035 Reset, then StartE=1 with MdOpE=00 for one cycle -> MdStart pulse in cycle 0, MdBusy cycles 1-5, MdDone pulse in cycle 5 with MdWriteEn=1, IDLE in cycle 6.
REQ-036 MdOpE=11 start, then HiLoReadD=1 held -> StallF, StallD and FlushE high cycles 0-33, released cycle 34; MdDone in cycle 33.
REQ-037 MemToRegE=1, RtE=5, RsD=5 with MdBusy=0 -> single-cycle stall+flush; RtE=0 with RsD=0 -> no stall.
REQ-038 MdOpE=10 start, rst=1 in cycle 10 -> IDLE in cycle 11, MdDone never pulses, MdOp=00.
REQ-039 MdOpE=10 with DivZeroE=1 -> with MD_DIV_ZERO_FAST_EN: MdDone in cycle 1, MdWriteEn=0; without it: MdDone in cycle 33, MdWriteEn=1.
REQ-040 Second StartE asserted in cycle 2 of a running mult -> ignored; exactly one MdDone, in cycle 5.

Source files
------------

// File: rtl/md_hazard_ctrl.sv
// Mul/div sequencing and pipeline hazard control: IDLE/RUN/DONE FSM for the iterative unit plus load-use and HI/LO stalls.
// Optional macro MD_DIV_ZERO_FAST_EN: a divide by zero skips RUN and finishes in DONE without writing HI/LO.
module md_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       StartE,
  input  logic [1:0] MdOpE,
  input  logic       DivZeroE,
  input  logic       StartD,
  input  logic       HiLoReadD,
  input  logic       HiLoWriteD,
  input  logic       MemToRegE,
  input  logic [4:0] RtE,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic       MdStart,
  output logic [1:0] MdOp,
  output logic       MdDone,
  output logic       MdWriteEn,
  output logic       MdBusy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_t     state_q = IDLE;
  state_t     state_d;
  logic [5:0] cnt_q = 6'd0;
  logic [5:0] cnt_d;
  logic [1:0] mdop_q = 2'b00;
  logic [1:0] mdop_d;
  logic       wen_q = 1'b0;
  logic       wen_d;
  logic       fast_s;
  logic       load_use_s;
  logic       hilo_use_s;
  logic       md_hazard_s;

`ifdef MD_DIV_ZERO_FAST_EN
  assign fast_s = MdOpE[1] & DivZeroE;
`else
  logic div_zero_unused;
  assign fast_s          = 1'b0;
  assign div_zero_unused = DivZeroE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      mdop_q  <= 2'b00;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mdop_q  <= mdop_d;
      wen_q   <= wen_d;
    end
  end

  // wen_q remembers whether the current op may update HI/LO when it reaches DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mdop_d  = mdop_q;
    wen_d   = wen_q;
    case (state_q)
      IDLE: begin
        if (StartE) begin
          mdop_d = MdOpE;
          if (fast_s) begin
            state_d = DONE;
            cnt_d   = 6'd0;
            wen_d   = 1'b0;
          end else begin
            state_d = RUN;
            cnt_d   = MdOpE[1] ? DIV_LOAD : MUL_LOAD;
            wen_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == 6'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_comb begin
    MdStart     = ~rst & (state_q == IDLE) & StartE & ~fast_s;
    MdBusy      = ~rst & (state_q != IDLE);
    MdDone      = ~rst & (state_q == DONE);
    MdWriteEn   = MdDone & wen_q;
    MdOp        = mdop_q;
    load_use_s  = MemToRegE & (RtE != 5'd0) & ((RtE == RsD) | (RtE == RtD));
    hilo_use_s  = StartD | HiLoReadD | HiLoWriteD;
    // Include the start cycle so an ID-stage HI/LO access cannot slip past the op entering EX
    md_hazard_s = (MdBusy | MdStart) & hilo_use_s;
    StallF      = load_use_s | md_hazard_s;
    StallD      = load_use_s | md_hazard_s;
    FlushE      = load_use_s | md_hazard_s;
  end

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Scoreboard bench for md_hazard_ctrl: a latency-count reference model pushes expected outputs per cycle.
module tb_md_hazard_ctrl;

  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 32;

  logic       clk, rst, StartE, DivZeroE, StartD, HiLoReadD, HiLoWriteD, MemToRegE;
  logic [1:0] MdOpE;
  logic [4:0] RtE, RsD, RtD;
  logic       StallF, StallD, FlushE, MdStart, MdDone, MdWriteEn, MdBusy;
  logic [1:0] MdOp;

  typedef struct packed {
    logic       st;
    logic       busy;
    logic       done;
    logic       wen;
    logic [1:0] op;
    logic       stall;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc, sc_done_cnt, sc_done_cyc, sc_last_stall, sc_stall_cnt, sc_wen;
  int m_rem = 0;
  logic [1:0] m_op = 2'b00;
  logic m_wen = 1'b0;

  md_hazard_ctrl #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst(rst), .StartE(StartE), .MdOpE(MdOpE), .DivZeroE(DivZeroE),
    .StartD(StartD), .HiLoReadD(HiLoReadD), .HiLoWriteD(HiLoWriteD),
    .MemToRegE(MemToRegE), .RtE(RtE), .RsD(RsD), .RtD(RtD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .MdStart(MdStart),
    .MdOp(MdOp), .MdDone(MdDone), .MdWriteEn(MdWriteEn), .MdBusy(MdBusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic fast_div(input logic [1:0] op, input logic dz);
`ifdef MD_DIV_ZERO_FAST_EN
    return op[1] & dz;
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_inputs();
    rst = 1'b0; StartE = 1'b0; MdOpE = 2'b00; DivZeroE = 1'b0; StartD = 1'b0;
    HiLoReadD = 1'b0; HiLoWriteD = 1'b0; MemToRegE = 1'b0;
    RtE = 5'd0; RsD = 5'd0; RtD = 5'd0;
  endtask

  task automatic begin_sc();
    cyc = 0; sc_done_cnt = 0; sc_done_cyc = -1; sc_last_stall = -1; sc_stall_cnt = 0; sc_wen = -1;
  endtask

  // One clock cycle with inputs already driven: predict, compare at negedge, advance model at posedge
  task automatic tick();
    exp_t e;
    logic lu, fast;
    fast    = fast_div(MdOpE, DivZeroE);
    e.busy  = !rst && (m_rem > 0);
    e.done  = !rst && (m_rem == 1);
    e.wen   = e.done && m_wen;
    e.st    = !rst && (m_rem == 0) && StartE && !fast;
    e.op    = m_op;
    lu      = MemToRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));
    e.stall = lu || ((e.busy || e.st) && (StartD || HiLoReadD || HiLoWriteD));
    exp_q.push_back(e);

    @(negedge clk);
    e = exp_q.pop_front();
    check_val("MdStart", MdStart, e.st);
    check_val("MdBusy", MdBusy, e.busy);
    check_val("MdDone", MdDone, e.done);
    check_val("MdWriteEn", MdWriteEn, e.wen);
    check_val("MdOp", MdOp, e.op);
    check_val("StallF", StallF, e.stall);
    check_val("StallD", StallD, e.stall);
    check_val("FlushE", FlushE, e.stall);
    if (MdDone) begin
      sc_done_cnt++;
      if (sc_done_cyc < 0) sc_done_cyc = cyc;
      sc_wen = MdWriteEn;
    end
    if (StallF) begin
      sc_last_stall = cyc;
      sc_stall_cnt++;
    end

    @(posedge clk);
    if (rst) begin
      m_rem = 0; m_op = 2'b00; m_wen = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
    end else if (StartE) begin
      m_op  = MdOpE;
      m_wen = !fast;
      m_rem = fast ? 1 : (MdOpE[1] ? DIV_CYCLES + 1 : MUL_CYCLES + 1);
    end
    #1;
    cyc++;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    begin_sc();
    for (int i = 0; i < 3; i++) tick();
    idle_inputs();
    tick();

    // Single mult: done in cycle 5
    begin_sc();
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      StartE = (i == 0);
      tick();
    end
    check_val("mul_done_cyc", sc_done_cyc, MUL_CYCLES + 1);
    check_val("mul_done_cnt", sc_done_cnt, 1);
    check_val("mul_wen", sc_wen, 1);

    // divu with HiLoReadD held: stall 0..33, release at 34
    begin_sc();
    for (int i = 0; i < 36; i++) begin
      idle_inputs();
      StartE = (i == 0); MdOpE = 2'b11; HiLoReadD = 1'b1;
      tick();
    end
    check_val("divu_done_cyc", sc_done_cyc, DIV_CYCLES + 1);
    check_val("divu_last_stall", sc_last_stall, DIV_CYCLES + 1);
    check_val("divu_stall_cnt", sc_stall_cnt, DIV_CYCLES + 2);

    // Load-use: rs match, r0 exemption, rt match
    begin_sc();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      MemToRegE = (i < 3);
      RtE = (i == 0) ? 5'd5 : ((i == 2) ? 5'd7 : 5'd0);
      RsD = (i == 0) ? 5'd5 : 5'd0;
      RtD = (i == 2) ? 5'd7 : 5'd0;
      tick();
    end
    check_val("lu_stall_cnt", sc_stall_cnt, 2);
    check_val("lu_last_stall", sc_last_stall, 2);

    // div aborted by reset in cycle 10
    begin_sc();
    for (int i = 0; i < 40; i++) begin
      idle_inputs();
      StartE = (i == 0); MdOpE = 2'b10; rst = (i == 10);
      tick();
    end
    check_val("abort_done_cnt", sc_done_cnt, 0);
    check_val("abort_mdop", MdOp, 0);

    // div by zero
    begin_sc();
    for (int i = 0; i < 36; i++) begin
      idle_inputs();
      StartE = (i == 0); MdOpE = 2'b10; DivZeroE = 1'b1;
      tick();
    end
`ifdef MD_DIV_ZERO_FAST_EN
    check_val("dz_done_cyc", sc_done_cyc, 1);
    check_val("dz_wen", sc_wen, 0);
`else
    check_val("dz_done_cyc", sc_done_cyc, DIV_CYCLES + 1);
    check_val("dz_wen", sc_wen, 1);
`endif
    check_val("dz_done_cnt", sc_done_cnt, 1);

    // Second StartE during a running mult is ignored
    begin_sc();
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      StartE = (i == 0) || (i == 2);
      MdOpE  = (i == 2) ? 2'b10 : 2'b00;
      tick();
    end
    check_val("dup_done_cnt", sc_done_cnt, 1);
    check_val("dup_done_cyc", sc_done_cyc, MUL_CYCLES + 1);

    // Random traffic against the model
    begin_sc();
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 49) == 0);
      StartE     = ($urandom_range(0, 3) == 0);
      MdOpE      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      DivZeroE   = ($urandom_range(0, 2) == 0);
      StartD     = ($urandom_range(0, 5) == 0);
      HiLoReadD  = ($urandom_range(0, 5) == 0);
      HiLoWriteD = ($urandom_range(0, 7) == 0);
      MemToRegE  = ($urandom_range(0, 3) == 0);
      RtE        = 5'($urandom_range(0, 3));
      RsD        = 5'($urandom_range(0, 3));
      RtD        = 5'($urandom_range(0, 3));
      tick();
    end
    check_val("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
